fir_tap_sequencer: RTL and testbench

//  Control FSM for a time-multiplexed (single-MAC) FIR datapath. Accepts samples over a

---
 rtl/fir_pkg.sv | 19 +
 rtl/fir_mod_counter.sv | 38 +++
 rtl/fir_tap_sequencer.sv | 99 +++++++++
 tb/tb_fir_tap_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and helpers for the time-multiplexed FIR tap sequencer.
package fir_pkg;

  localparam int NTAPS_DEF = 8;

  typedef enum logic [1:0] {
    ST_ZERO,
    ST_IDLE,
    ST_MAC,
    ST_DONE
  } state_e;

  // (ptr - k) mod n using one compare and one add; the caller keeps ptr, k < n.
  function automatic int unsigned wrap_dec(input int unsigned ptr, input int unsigned k,
                                           input int unsigned n);
    return (ptr >= k) ? (ptr - k) : (ptr + n - k);
  endfunction

endpackage

// File: rtl/fir_mod_counter.sv
// Modulo-N up counter with synchronous clear; clear wins over increment.
module fir_mod_counter #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MAX = W'(N - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: the default assignment on the first line keeps this block free of latches.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = (cnt_q == MAX) ? '0 : cnt_q + 1'b1;
    end
  end

  // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/fir_tap_sequencer.sv
// Control FSM for a single-MAC FIR: zero-walks the sample RAM, accepts one sample,
// steps NTAPS MAC cycles with matched sample/coef addresses, then offers the result.
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter int NTAPS = NTAPS_DEF,
  parameter int AW    = $clog2(NTAPS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          smp_we,
  output logic          smp_zero,
  output logic [AW-1:0] smp_waddr,
  output logic [AW-1:0] smp_raddr,
  output logic [AW-1:0] coef_addr,
  output logic          mac_clr,
  output logic          mac_en
);

  localparam logic [AW-1:0] K_LAST = AW'(NTAPS - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] k, wr_ptr;
  logic          k_last, accept;
  logic          in_zero, in_idle, in_mac, in_done;

  assign in_zero = (state_q == ST_ZERO);
  assign in_idle = (state_q == ST_IDLE);
  assign in_mac  = (state_q == ST_MAC);
  assign in_done = (state_q == ST_DONE);
  assign k_last  = (k == K_LAST);

  assign in_ready = in_idle && !clear;
  assign accept   = in_ready && in_valid;

  fir_mod_counter #(.N(NTAPS), .W(AW)) u_tap_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear || accept),
    .inc   (in_zero || in_mac),
    .cnt   (k)
  );

  // wr_ptr is parked at 0 for the whole zero walk, so it leaves ZERO at 0.
  fir_mod_counter #(.N(NTAPS), .W(AW)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (in_zero),
    .inc   (accept),
    .cnt   (wr_ptr)
  );

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    unique case (state_q)
      ST_ZERO: if (k_last) state_d = ST_IDLE;
      ST_IDLE: if (accept) begin
        state_d = ST_MAC;
        base_d  = wr_ptr;
      end
      ST_MAC:  if (k_last) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_ZERO;
    endcase
    if (clear) state_d = ST_ZERO;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ZERO;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
    end
  end

  // The zero walk is held off while rst_n is low so reset presents idle-valued strobes.
  assign smp_zero  = in_zero && rst_n && !clear;
  assign smp_we    = smp_zero || accept;
  assign smp_waddr = in_idle ? wr_ptr : (in_zero ? k : '0);

  assign mac_en    = in_mac && !clear;
  assign mac_clr   = mac_en && (k == '0);
  assign coef_addr = in_mac ? k : '0;
  assign smp_raddr = in_mac ? AW'(wrap_dec(32'(base_q), 32'(k), NTAPS)) : '0;

  assign out_valid = in_done && !clear;
  assign busy      = !in_idle;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench: an NTAPS=8 instance and an NTAPS=5 instance driven from shared clock/reset.
module tb_fir_tap_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_clear, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic       a_smp_we, a_smp_zero, a_mac_clr, a_mac_en;
  logic [2:0] a_smp_waddr, a_smp_raddr, a_coef_addr;

  logic       b_clear, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic       b_smp_we, b_smp_zero, b_mac_clr, b_mac_en;
  logic [2:0] b_smp_waddr, b_smp_raddr, b_coef_addr;

  fir_tap_sequencer #(.NTAPS(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .clear(a_clear), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .busy(a_busy), .smp_we(a_smp_we),
    .smp_zero(a_smp_zero), .smp_waddr(a_smp_waddr), .smp_raddr(a_smp_raddr),
    .coef_addr(a_coef_addr), .mac_clr(a_mac_clr), .mac_en(a_mac_en)
  );

  fir_tap_sequencer #(.NTAPS(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .clear(b_clear), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .busy(b_busy), .smp_we(b_smp_we),
    .smp_zero(b_smp_zero), .smp_waddr(b_smp_waddr), .smp_raddr(b_smp_raddr),
    .coef_addr(b_coef_addr), .mac_clr(b_mac_clr), .mac_en(b_mac_en)
  );

  typedef struct {
    int raddr;
    int coef;
    int clr;
  } mac_vec_t;

  mac_vec_t vec8[8];
  mac_vec_t vec5[5];
  int       burst_waddr[10];
  int       b_waddr[7];
  int       n_checks = 0;
  int       n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepts;
    int last_c;

    vec8[0] = '{0, 0, 1}; vec8[1] = '{7, 1, 0}; vec8[2] = '{6, 2, 0}; vec8[3] = '{5, 3, 0};
    vec8[4] = '{4, 4, 0}; vec8[5] = '{3, 5, 0}; vec8[6] = '{2, 6, 0}; vec8[7] = '{1, 7, 0};
    vec5[0] = '{1, 0, 1}; vec5[1] = '{0, 1, 0}; vec5[2] = '{4, 2, 0}; vec5[3] = '{3, 3, 0};
    vec5[4] = '{2, 4, 0};
    burst_waddr = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
    b_waddr     = '{0, 1, 2, 3, 4, 0, 1};

    a_clear = 0; a_in_valid = 0; a_out_ready = 0;
    b_clear = 0; b_in_valid = 0; b_out_ready = 0;

    // Reset asserted
    #3;
    check("rst_busy", int'(a_busy), 1);
    check("rst_smp_we", int'(a_smp_we), 0);
    check("rst_smp_zero", int'(a_smp_zero), 0);
    check("rst_in_ready", int'(a_in_ready), 0);
    check("rst_out_valid", int'(a_out_valid), 0);
    check("rst_mac_en", int'(a_mac_en), 0);
    check("rst_b_busy", int'(b_busy), 1);

    // Zero walk after release
    #9 rst_n = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("zero_we[%0d]", i), int'(a_smp_we), 1);
      check($sformatf("zero_zero[%0d]", i), int'(a_smp_zero), 1);
      check($sformatf("zero_waddr[%0d]", i), int'(a_smp_waddr), i);
      check($sformatf("zero_busy[%0d]", i), int'(a_busy), 1);
      cyc();
    end
    check("idle_busy", int'(a_busy), 0);
    check("idle_in_ready", int'(a_in_ready), 1);
    check("idle_smp_we", int'(a_smp_we), 0);

    // Single sample at wr_ptr=0
    a_in_valid = 1; #1;
    check("acc_we", int'(a_smp_we), 1);
    check("acc_waddr", int'(a_smp_waddr), 0);
    check("acc_zero", int'(a_smp_zero), 0);
    cyc();
    a_in_valid = 0; #1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("mac8_en[%0d]", k), int'(a_mac_en), 1);
      check($sformatf("mac8_clr[%0d]", k), int'(a_mac_clr), vec8[k].clr);
      check($sformatf("mac8_coef[%0d]", k), int'(a_coef_addr), vec8[k].coef);
      check($sformatf("mac8_raddr[%0d]", k), int'(a_smp_raddr), vec8[k].raddr);
      check($sformatf("mac8_ov[%0d]", k), int'(a_out_valid), 0);
      check($sformatf("mac8_in_ready[%0d]", k), int'(a_in_ready), 0);
      cyc();
    end
    check("done_out_valid", int'(a_out_valid), 1);
    check("done_mac_en", int'(a_mac_en), 0);

    // Sink stalls 5 cycles; in_valid pulses must not be consumed
    for (int i = 0; i < 5; i++) begin
      a_in_valid = (i % 2 == 0); #1;
      check($sformatf("stall_ov[%0d]", i), int'(a_out_valid), 1);
      check($sformatf("stall_in_ready[%0d]", i), int'(a_in_ready), 0);
      check($sformatf("stall_we[%0d]", i), int'(a_smp_we), 0);
      cyc();
    end
    a_in_valid = 0; a_out_ready = 1; #1;
    check("hs_out_valid", int'(a_out_valid), 1);
    cyc();
    check("post_hs_ov", int'(a_out_valid), 0);
    check("post_hs_in_ready", int'(a_in_ready), 1);

    // Ten back-to-back samples, sink always ready
    a_in_valid = 1;
    accepts = 0;
    last_c = 0;
    for (int c = 0; c < 300 && accepts < 10; c++) begin
      #1;
      if (a_in_ready) begin
        check($sformatf("burst_waddr[%0d]", accepts), int'(a_smp_waddr), burst_waddr[accepts]);
        if (accepts > 0) check($sformatf("burst_gap[%0d]", accepts), c - last_c, 10);
        last_c = c;
        accepts++;
      end
      cyc();
    end
    a_in_valid = 0;
    check("burst_accepts", accepts, 10);
    repeat (12) cyc();
    check("burst_end_in_ready", int'(a_in_ready), 1);

    // NTAPS=5: seven samples, the seventh lands at address 1
    b_out_ready = 1;
    b_in_valid = 1;
    accepts = 0;
    for (int c = 0; c < 300 && accepts < 7; c++) begin
      #1;
      if (b_in_ready) begin
        check($sformatf("b_waddr[%0d]", accepts), int'(b_smp_waddr), b_waddr[accepts]);
        accepts++;
      end
      cyc();
    end
    b_in_valid = 0;
    check("b_accepts", accepts, 7);
    #1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("mac5_clr[%0d]", k), int'(b_mac_clr), vec5[k].clr);
      check($sformatf("mac5_coef[%0d]", k), int'(b_coef_addr), vec5[k].coef);
      check($sformatf("mac5_raddr[%0d]", k), int'(b_smp_raddr), vec5[k].raddr);
      cyc();
    end
    check("b_done_ov", int'(b_out_valid), 1);
    cyc();
    check("b_idle_in_ready", int'(b_in_ready), 1);

    // Clear at MAC k=3 on the NTAPS=5 instance
    b_in_valid = 1; #1;
    check("b_clr_acc_waddr", int'(b_smp_waddr), 2);
    cyc();
    b_in_valid = 0;
    repeat (3) cyc();
    check("b_pre_clear_k", int'(b_coef_addr), 3);
    b_clear = 1; b_in_valid = 1; #1;
    check("b_clear_in_ready", int'(b_in_ready), 0);
    check("b_clear_we", int'(b_smp_we), 0);
    check("b_clear_mac_en", int'(b_mac_en), 0);
    cyc();
    b_clear = 0; b_in_valid = 0; #1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("b_rezero_we[%0d]", i), int'(b_smp_we), 1);
      check($sformatf("b_rezero_zero[%0d]", i), int'(b_smp_zero), 1);
      check($sformatf("b_rezero_waddr[%0d]", i), int'(b_smp_waddr), i);
      check($sformatf("b_rezero_ov[%0d]", i), int'(b_out_valid), 0);
      cyc();
    end
    check("b_after_clear_in_ready", int'(b_in_ready), 1);
    b_in_valid = 1; #1;
    check("b_after_clear_we", int'(b_smp_we), 1);
    check("b_after_clear_waddr", int'(b_smp_waddr), 0);
    cyc();
    b_in_valid = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
